// File: rtl/op_dispatcher_if.sv
// op_dispatcher_if: op handshake bundle shared by the upstream op queue,
// the dispatcher (master) and the handler side (slave).
interface op_dispatcher_if;

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] num;
    } op_st;

    op_st op_in;
    logic op_valid;
    logic op_rdy;
    op_st op_out;
    logic handler_trigger;
    logic handler_rdy;
    logic handler_done;

    modport master (
        input  op_in,
        input  op_valid,
        input  handler_rdy,
        input  handler_done,
        output op_rdy,
        output op_out,
        output handler_trigger
    );

    modport slave (
        output op_in,
        output op_valid,
        output handler_rdy,
        output handler_done,
        input  op_rdy,
        input  op_out,
        input  handler_trigger
    );

endinterface

// File: rtl/op_dispatcher.sv
// op_dispatcher: accepts one op at a time, triggers the chosen handler and
// counts completions. OP_DISPATCH_TIMEOUT_EN adds a sticky hang detector.
module op_dispatcher #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    op_dispatcher_if.master        bus,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] done_count,
    output logic                   timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        TRIGGER,
        WAIT_DONE,
        ERROR
    } state_t;

    state_t state;
    state_t state_d;
    logic   accept;
    logic   finish;
    logic   tmo_hit;

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        finish  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.op_valid) begin
                    accept  = 1'b1;
                    state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (tmo_hit) begin
                    state_d = ERROR;
                end else if (bus.handler_rdy) begin
                    state_d = TRIGGER;
                end
            end
            TRIGGER: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tmo_hit) begin
                    state_d = ERROR;
                end else if (bus.handler_done) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // op_out holds its value in IDLE because the chooser routes on it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bus.op_out <= '0;
            done_count <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                bus.op_out <= bus.op_in;
            end
            if (finish) begin
                done_count <= done_count + 1'b1;
            end
        end
    end

    assign bus.op_rdy          = (state == IDLE);
    assign bus.handler_trigger = (state == TRIGGER);
    assign busy                = (state != IDLE);

`ifdef OP_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_err_q;
    logic          waiting;

    assign waiting = (state == WAIT_RDY) || (state == WAIT_DONE);
    // the cycle that would bring the count to the limit moves to ERROR
    assign tmo_hit = waiting && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt   <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if (accept) begin
                tmo_cnt <= '0;
            end else if (waiting) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (state_d == ERROR) begin
                tmo_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;

    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
    end
`endif

endmodule

// File: tb/tb_op_dispatcher.sv
// tb_op_dispatcher: random op stream with a handler model; a monitor checks
// trigger timing, routed op and completion counts against queued predictions.
module tb_op_dispatcher;

    typedef struct {
        logic [15:0] op;
        int          cyc;
    } trig_t;

    typedef struct {
        logic [15:0] op;
        logic [3:0]  cnt;
    } done_t;

    localparam int N_OPS = 24;
`ifdef OP_DISPATCH_TIMEOUT_EN
    localparam int LONG_RDY = 3;
    localparam int RDY_MAX  = 2;
    localparam int DONE_MAX = 3;
    localparam bit EXP_TMO  = 1'b1;
`else
    localparam int LONG_RDY = 10;
    localparam int RDY_MAX  = 3;
    localparam int DONE_MAX = 5;
    localparam bit EXP_TMO  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [3:0] done_count;
    logic       timeout_err;

    op_dispatcher_if dif();

    op_dispatcher #(
        .TIMEOUT_CYCLES(8),
        .COUNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(dif.master),
        .busy(busy),
        .done_count(done_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_chk = 0;
    int          n_pass = 0;
    trig_t       trig_q[$];
    done_t       done_q[$];
    logic [3:0]  exp_cnt = '0;
    logic        real_done = 1'b0;
    logic [15:0] ops[N_OPS + 1];

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endfunction

    function automatic void fail_now(string name);
        n_chk++;
        $display("FAIL %s: event seen, none expected", name);
    endfunction

    // monitor
    initial begin
        bit    pend;
        trig_t t;
        done_t d;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (done_q.size() == 0) begin
                    fail_now("done_unexpected");
                end else begin
                    d = done_q.pop_front();
                    chk("done_count", 32'(done_count), 32'(d.cnt));
                    chk("op_rdy_after_done", 32'(dif.op_rdy), 1);
                    chk("op_out_hold", 32'(dif.op_out), 32'(d.op));
                end
            end
            pend = real_done;
            if (dif.handler_trigger === 1'b1) begin
                if (trig_q.size() == 0) begin
                    fail_now("trigger_unexpected");
                end else begin
                    t = trig_q.pop_front();
                    chk("trig_cycle", 32'(cyc), 32'(t.cyc));
                    chk("trig_op", 32'(dif.op_out), 32'(t.op));
                end
            end
        end
    end

    task automatic run_op(input logic [15:0] op, input logic [15:0] nxt,
                          input int rdy_dly, input int done_dly,
                          input bit hold, input bit spur);
        int acc;
        dif.op_in    = op;
        dif.op_valid = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        trig_q.push_back('{op, acc + 1 + rdy_dly});
        dif.op_in       = nxt;
        dif.op_valid    = hold;
        dif.handler_rdy = 1'b0;
        repeat (rdy_dly) begin
            dif.handler_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
        dif.handler_rdy  = 1'b1;
        dif.handler_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        dif.handler_rdy  = 1'($urandom_range(0, 1));
        dif.handler_done = 1'b0;
        @(posedge clk); #1;
        dif.handler_rdy = 1'($urandom_range(0, 1));
        repeat (done_dly) begin
            @(posedge clk); #1;
        end
        dif.handler_done = 1'b1;
        real_done        = 1'b1;
        exp_cnt          = exp_cnt + 1'b1;
        done_q.push_back('{op, exp_cnt});
        @(posedge clk); #1;
        dif.handler_done = 1'b0;
        real_done        = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_op_rdy", 32'(dif.op_rdy), 1);
        chk("rst_trigger", 32'(dif.handler_trigger), 0);
        chk("rst_done_count", 32'(done_count), 0);
        chk("rst_op_out", 32'(dif.op_out), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        exp_cnt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] letters[3];
        int rd, dd;
        bit hold, spur;
        letters = '{8'h47, 8'h4D, 8'h54};
        ops[0] = {8'h47, 8'd1};
        ops[1] = {8'h47, 8'd2};
        ops[2] = {8'h4D, 8'd5};
        for (int i = 3; i <= N_OPS; i++)
            ops[i] = {letters[$urandom_range(0, 2)],
                      8'($urandom_range(0, 99))};
        dif.op_in        = '0;
        dif.op_valid     = 1'b0;
        dif.handler_rdy  = 1'b0;
        dif.handler_done = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("post_rst_op_rdy", 32'(dif.op_rdy), 1);
        chk("post_rst_busy", 32'(busy), 0);
        @(posedge clk); #1;

        for (int i = 0; i < N_OPS; i++) begin
            rd   = $urandom_range(0, RDY_MAX);
            dd   = $urandom_range(0, DONE_MAX);
            hold = 1'($urandom_range(0, 1));
            spur = 1'($urandom_range(0, 1));
            if (i == 0) begin
                rd = 0; dd = 4; hold = 1'b0; spur = 1'b0;
            end else if (i == 1) begin
                rd = 0; dd = 2; hold = 1'b1; spur = 1'b0;
            end else if (i == 2) begin
                rd = LONG_RDY; dd = 0; hold = 1'b0; spur = 1'b1;
            end
            run_op(ops[i], ops[i + 1], rd, dd, hold, spur);
            if (i == 16) chk("wrap_17_ops", 32'(done_count), 1);
        end
        dif.op_valid = 1'b0;

        // reset while waiting for the handler to finish
        dif.op_in    = 16'h4731;
        dif.op_valid = 1'b1;
        @(posedge clk); #1;
        trig_q.push_back('{16'h4731, cyc + 1});
        dif.op_valid    = 1'b0;
        dif.handler_rdy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        dif.handler_rdy = 1'b0;
        #2;
        do_reset();
        @(posedge clk); #1;
        dif.handler_done = 1'b1;
        @(posedge clk); #1;
        dif.handler_done = 1'b0;
        chk("late_done_ignored", 32'(done_count), 0);

        // handler never becomes ready
        dif.op_in    = 16'h4D09;
        dif.op_valid = 1'b1;
        @(posedge clk); #1;
        dif.op_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        chk("tmo_not_early", 32'(timeout_err), 0);
        @(posedge clk); #1;
        chk("tmo_at_limit", 32'(timeout_err), 32'(EXP_TMO));
        repeat (12) begin
            @(posedge clk); #1;
        end
        dif.op_valid = 1'b1;
        @(posedge clk); #1;
        dif.op_valid = 1'b0;
        chk("tmo_sticky", 32'(timeout_err), 32'(EXP_TMO));
        chk("hang_op_rdy", 32'(dif.op_rdy), 0);
        chk("hang_busy", 32'(busy), 1);
        chk("hang_op_out", 32'(dif.op_out), 32'h4D09);
        do_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("trig_q_drained", 32'(trig_q.size()), 0);
        chk("done_q_drained", 32'(done_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/op_dispatcher.md
OP_DISPATCHER -- requirements
Module: op_dispatcher

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the max cycles allowed in WAIT_RDY+WAIT_DONE per op (used only with OP_DISPATCH_TIMEOUT_EN).
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, meaning the width of the completed-op counter.
REQ-003 SHALL have one clock and an asynchronous active-low reset; ports: clk  in  1  system clock.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 op_in  in  Op_st  opcode offered by upstream op queue.
REQ-006 op_valid  in  1  op_in valid.
REQ-007 op_rdy  out  1  dispatcher can accept an op this cycle.
REQ-008 op_out  out  Op_st  latched op driven to the handler input chooser.
REQ-009 handler_trigger  out  1  one-cycle start pulse toward the chosen handler.
REQ-010 handler_rdy  in  1  chosen handler idle and ready.
REQ-011 handler_done  in  1  chosen handler finished.
REQ-012 busy  out  1  op in flight (state != IDLE).
REQ-013 done_count  out  COUNT_WIDTH  number of completed ops.
REQ-014 timeout_err  out  1  sticky handler-hang flag.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_RDY, TRIGGER, WAIT_DONE, ERROR.
REQ-016 IDLE: op_rdy=1; on op_valid&&op_rdy latch op_in into op_out and go to WAIT_RDY; otherwise stay.
REQ-017 WAIT_RDY: op_rdy=0; when handler_rdy=1 go to TRIGGER; otherwise stay.
REQ-018 TRIGGER: handler_trigger=1 for exactly this one cycle; unconditionally go to WAIT_DONE.
REQ-019 WAIT_DONE: on handler_done=1 go to IDLE and increment done_count; handler_done in any other state SHALL be ignored.
REQ-020 handler_trigger SHALL be 0 in every state except TRIGGER.
REQ-021 op_out SHALL be stable from the accept cycle until the next accept, including in IDLE (the downstream chooser routes combinationally on op_out.cmd).
REQ-022 Latency: accept at cycle N with handler_rdy=1 gives handler_trigger=1 at cycle N+2; done at cycle M gives op_rdy=1 at cycle M+1.
REQ-023 At most one op in flight; no new accept before the IDLE state is re-entered.
REQ-024 done_count SHALL wrap from all-ones to 0 without error.
REQ-025 Simultaneous handler_rdy and handler_done in WAIT_RDY: go to TRIGGER; done ignored.
REQ-026 busy SHALL equal (state != IDLE); in ERROR busy=1.

Reset
REQ-027 Asserting reset (low) at any time, including mid-op, SHALL immediately force state IDLE, op_out=0, handler_trigger=0, done_count=0, timeout_err=0, timeout counter=0.
REQ-028 In the first cycle after reset release, op_rdy=1 and busy=0.

Configuration
REQ-029 Macro OP_DISPATCH_TIMEOUT_EN defined: a counter SHALL clear on accept and increment each cycle in WAIT_RDY or WAIT_DONE; when it reaches TIMEOUT_CYCLES, FSM enters ERROR and timeout_err=1.
REQ-030 In ERROR, op_rdy=0 and handler_trigger=0; ERROR is left only by reset.
REQ-031 Macro undefined: no counter is present, ERROR is unreachable, timeout_err is tied 0, and the FSM waits indefinitely.

Verification
REQ-032 Single op G01 with handler_rdy=1 and done 5 cycles after trigger -> trigger at accept+2 for 1 cycle, done_count=1, op_rdy high the cycle after done.
REQ-033 Back-to-back G02 then M05 with op_valid held -> two triggers, op_out.cmd changes only on the second accept, done_count=2.
REQ-034 handler_rdy low for 10 cycles after accept -> no trigger until rdy rises, then trigger 1 cycle later; spurious done during WAIT_RDY has no effect on done_count.
REQ-035 Reset asserted in WAIT_DONE -> all outputs return to reset values asynchronously, and a later done pulse leaves done_count=0.
REQ-036 COUNT_WIDTH=4 with 17 ops -> done_count=1 after wrap.
REQ-037 OP_DISPATCH_TIMEOUT_EN with TIMEOUT_CYCLES=8 and done never asserted -> timeout_err=1 at accept+9, op_rdy stays 0 until reset; without the macro, timeout_err stays 0.
